// File: rtl/result_bus_arbiter_pkg.sv
// Shared definitions for the reservation-station blocks: default widths,
// the broadcast lane layout, operation encodings and a small index helper.
package result_bus_arbiter_pkg;

   localparam int unsigned DEF_SIZE               = 32'd32;
   localparam int unsigned DEF_STATION_INDEX_SIZE = 32'd2;
   localparam int unsigned DEF_STATION_COUNT      = 32'd4;
   localparam int unsigned DEF_BUS_COUNT          = 32'd1;

   // Operation encodings shared with the execution units.
   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SLL = 3'd5,
      OP_SRL = 3'd6,
      OP_SLT = 3'd7
   } op_e;

   // One broadcast lane at the default widths, as seen by stations and the
   // register file. Blocks built with other widths declare the same layout
   // locally from their own parameters.
   typedef struct packed {
      logic                              asserted;
      logic [DEF_STATION_INDEX_SIZE-1:0] source;
      logic [DEF_SIZE-1:0]               value;
   } bus_lane_t;

   // Increment a station index, wrapping at the station count (which need
   // not be a power of two).
   function automatic int unsigned wrap_inc(input int unsigned idx,
                                            input int unsigned count);
      int unsigned nxt;
      nxt = idx + 32'd1;
      if (nxt >= count) begin
         nxt = 32'd0;
      end else begin
         nxt = nxt;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/result_bus_arbiter_if.sv
// Station-side and bus-side signals of the result bus arbiter.
// Bit/element i of the station vectors belongs to station i.
interface result_bus_arbiter_if #(
   parameter int SIZE               = 32,
   parameter int STATION_INDEX_SIZE = 2,
   parameter int STATION_COUNT      = 4,
   parameter int BUS_COUNT          = 1
);

   logic [STATION_COUNT-1:0]      station_ready;
   logic [SIZE-1:0]               station_result  [STATION_COUNT];
   logic [STATION_COUNT-1:0]      station_release;
   logic [BUS_COUNT-1:0]          bus_asserted;
   logic [STATION_INDEX_SIZE-1:0] bus_source      [BUS_COUNT];
   logic [SIZE-1:0]               bus_value       [BUS_COUNT];

   // Arbiter side: consumes station results, drives the lanes and releases.
   modport master (
      input  station_ready,
      input  station_result,
      output station_release,
      output bus_asserted,
      output bus_source,
      output bus_value
   );

   // Station/dispatcher side.
   modport slave (
      output station_ready,
      output station_result,
      input  station_release,
      input  bus_asserted,
      input  bus_source,
      input  bus_value
   );

endinterface

// File: rtl/result_bus_arbiter_round_robin_picker.sv
// Combinational round-robin search: returns the first set bit of the
// eligible mask at or after the pointer, wrapping at STATION_COUNT.
module round_robin_picker #(
   parameter int STATION_COUNT = 4,
   parameter int IDX_W         = 2
) (
   input  logic [STATION_COUNT-1:0] eligible_i,
   input  logic [IDX_W-1:0]         pointer_i,
   output logic [IDX_W-1:0]         index_o,
   output logic                     found_o
);

   // Two passes: stations from the pointer upward, then the wrapped part
   // below the pointer; the first hit wins.
   always_comb begin
      index_o = '0;
      found_o = 1'b0;
      for (int s = 0; s < STATION_COUNT; s++) begin
         if (!found_o && (s >= int'(pointer_i)) && eligible_i[s]) begin
            found_o = 1'b1;
            index_o = IDX_W'(s);
         end else begin
            found_o = found_o;
         end
      end
      for (int s = 0; s < STATION_COUNT; s++) begin
         if (!found_o && (s < int'(pointer_i)) && eligible_i[s]) begin
            found_o = 1'b1;
            index_o = IDX_W'(s);
         end else begin
            found_o = found_o;
         end
      end
   end

endmodule

// File: rtl/result_bus_arbiter.sv
// Result bus arbiter: each cycle grants up to BUS_COUNT ready stations in
// round-robin order, broadcasts their results on registered lanes and
// pulses a one-cycle release back to the dispatcher.
module result_bus_arbiter
   import result_bus_arbiter_pkg::*;
#(
   parameter int SIZE               = 32,
   parameter int STATION_INDEX_SIZE = 2,
   parameter int STATION_COUNT      = 4,
   parameter int BUS_COUNT          = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   result_bus_arbiter_if.master bus
);

   localparam int PTR_W = STATION_INDEX_SIZE;

   typedef struct packed {
      logic                          asserted;
      logic [STATION_INDEX_SIZE-1:0] source;
      logic [SIZE-1:0]               value;
   } lane_t;

   lane_t                    lane_q     [BUS_COUNT];
   lane_t                    lane_d     [BUS_COUNT];
   logic [STATION_COUNT-1:0] release_q;
   logic [STATION_COUNT-1:0] release_d;
   logic [PTR_W-1:0]         ptr_q;
   logic [PTR_W-1:0]         ptr_d;

   logic [STATION_COUNT-1:0] eligible_s;
   logic [STATION_COUNT-1:0] mask_s     [BUS_COUNT];
   logic [PTR_W-1:0]         pick_idx_s [BUS_COUNT];
   logic [BUS_COUNT-1:0]     pick_found_s;

   // A station shown on the bus this cycle still has ready high; the
   // release register keeps it from being granted twice in a row.
   assign eligible_s = bus.station_ready & ~release_q;
   assign mask_s[0]  = eligible_s;

   // Picker chain: every lane restarts at the pointer with the earlier
   // lanes' picks removed, so lane k gets the (k+1)-th eligible station.
   for (genvar k = 0; k < BUS_COUNT; k++) begin : g_lane
      round_robin_picker #(
         .STATION_COUNT (STATION_COUNT),
         .IDX_W         (PTR_W)
      ) u_picker (
         .eligible_i (mask_s[k]),
         .pointer_i  (ptr_q),
         .index_o    (pick_idx_s[k]),
         .found_o    (pick_found_s[k])
      );

      if (k < BUS_COUNT - 1) begin : g_mask
         assign mask_s[k+1] = mask_s[k] &
            ~(pick_found_s[k] ?
              ({{(STATION_COUNT-1){1'b0}}, 1'b1} << pick_idx_s[k]) :
              {STATION_COUNT{1'b0}});
      end

      assign bus.bus_asserted[k] = lane_q[k].asserted;
      assign bus.bus_source[k]   = lane_q[k].source;
      assign bus.bus_value[k]    = lane_q[k].value;
   end

   assign bus.station_release = release_q;

   // Next lane contents, release pulses and pointer; grants form a prefix
   // of the lanes, so the last granted lane sets the new pointer.
   always_comb begin
      release_d = '0;
      ptr_d     = ptr_q;
      for (int k = 0; k < BUS_COUNT; k++) begin
         lane_d[k] = '0;
         if (pick_found_s[k]) begin
            lane_d[k].asserted = 1'b1;
            lane_d[k].source   = STATION_INDEX_SIZE'(pick_idx_s[k]);
            for (int s = 0; s < STATION_COUNT; s++) begin
               if (pick_idx_s[k] == PTR_W'(s)) begin
                  lane_d[k].value = bus.station_result[s];
                  release_d[s]    = 1'b1;
               end else begin
                  release_d[s] = release_d[s];
               end
            end
            ptr_d = PTR_W'(wrap_inc(32'(pick_idx_s[k]), 32'(STATION_COUNT)));
         end else begin
            lane_d[k] = '0;
         end
      end
   end

   // Lane, release and pointer registers; reset drops any pending
   // broadcast and restarts arbitration at station 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < BUS_COUNT; k++) begin
            lane_q[k] <= '0;
         end
         release_q <= '0;
         ptr_q     <= '0;
      end else begin
         for (int k = 0; k < BUS_COUNT; k++) begin
            lane_q[k] <= lane_d[k];
         end
         release_q <= release_d;
         ptr_q     <= ptr_d;
      end
   end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Randomized scoreboard bench for result_bus_arbiter. Two instances:
// A = 4 stations / 1 lane, B = 3 stations / 2 lanes (non power-of-two wrap).
module tb_result_bus_arbiter;

   typedef struct {
      logic [1:0]  asrt;
      int          src [2];
      logic [31:0] val [2];
      logic [3:0]  rel;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   result_bus_arbiter_if #(.SIZE(32), .STATION_INDEX_SIZE(2),
                           .STATION_COUNT(4), .BUS_COUNT(1)) ifa ();
   result_bus_arbiter_if #(.SIZE(32), .STATION_INDEX_SIZE(2),
                           .STATION_COUNT(3), .BUS_COUNT(2)) ifb ();

   result_bus_arbiter #(.SIZE(32), .STATION_INDEX_SIZE(2),
                        .STATION_COUNT(4), .BUS_COUNT(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   result_bus_arbiter #(.SIZE(32), .STATION_INDEX_SIZE(2),
                        .STATION_COUNT(3), .BUS_COUNT(2)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   int n_tests = 0;
   int n_fail  = 0;

   exp_t q_a [$];
   exp_t q_b [$];

   // Dispatcher and reference-model state, per instance.
   logic [3:0]  rdy  [2];
   logic [31:0] res  [2][4];
   logic [3:0]  drop [2];
   logic [3:0]  mrel [2];
   int          mptr [2];
   bit          rst_done = 1'b0;

   function automatic int n_of(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   function automatic int b_of(input int d);
      return (d == 0) ? 1 : 2;
   endfunction

   // Reference model: walk stations in round-robin order from the pointer,
   // hand the eligible ones to lanes in turn, then move the pointer past
   // the last one served.
   task automatic model_step(input int d);
      int   picks [$];
      exp_t e;
      int   n;
      int   b;
      n      = n_of(d);
      b      = b_of(d);
      e.asrt = 2'b00;
      e.rel  = 4'b0000;
      for (int k = 0; k < 2; k++) begin
         e.src[k] = 0;
         e.val[k] = 32'h0;
      end
      for (int j = 0; j < n; j++) begin
         int s;
         s = (mptr[d] + j) % n;
         if (rdy[d][s] && !mrel[d][s] && picks.size() < b) picks.push_back(s);
      end
      for (int k = 0; k < picks.size(); k++) begin
         e.asrt[k]        = 1'b1;
         e.src[k]         = picks[k];
         e.val[k]         = res[d][picks[k]];
         e.rel[picks[k]]  = 1'b1;
      end
      if (picks.size() > 0) mptr[d] = (picks[picks.size()-1] + 1) % n;
      mrel[d] = e.rel;
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
   endtask

   // Dispatcher: keeps ready through the release cycle, drops it for at
   // least one cycle afterwards, then randomly reissues with a new value.
   task automatic dispatch(input int d);
      for (int i = 0; i < n_of(d); i++) begin
         if (mrel[d][i]) begin
            drop[d][i] = 1'b1;
         end else if (drop[d][i]) begin
            rdy[d][i]  = 1'b0;
            drop[d][i] = 1'b0;
         end else if (!rdy[d][i] && ($urandom_range(0, 2) != 0)) begin
            rdy[d][i] = 1'b1;
            res[d][i] = $urandom;
         end
      end
   endtask

   task automatic drive();
      ifa.station_ready = rdy[0];
      for (int i = 0; i < 4; i++) ifa.station_result[i] = res[0][i];
      ifb.station_ready = rdy[1][2:0];
      for (int i = 0; i < 3; i++) ifb.station_result[i] = res[1][i];
   endtask

   function automatic exp_t sample(input int d);
      exp_t a;
      if (d == 0) begin
         a.asrt   = {1'b0, ifa.bus_asserted};
         a.src[0] = int'(ifa.bus_source[0]);
         a.val[0] = ifa.bus_value[0];
         a.src[1] = 0;
         a.val[1] = 32'h0;
         a.rel    = ifa.station_release;
      end else begin
         a.asrt   = ifb.bus_asserted;
         a.src[0] = int'(ifb.bus_source[0]);
         a.val[0] = ifb.bus_value[0];
         a.src[1] = int'(ifb.bus_source[1]);
         a.val[1] = ifb.bus_value[1];
         a.rel    = {1'b0, ifb.station_release};
      end
      return a;
   endfunction

   task automatic compare(input string name, input exp_t e, input exp_t a);
      n_tests++;
      if (e.asrt !== a.asrt || e.rel !== a.rel || e.src[0] != a.src[0] ||
          e.src[1] != a.src[1] || e.val[0] !== a.val[0] ||
          e.val[1] !== a.val[1]) begin
         n_fail++;
         $display("FAIL %s @%0t: got asrt=%b src=%0d/%0d val=%h/%h rel=%b, want asrt=%b src=%0d/%0d val=%h/%h rel=%b",
                  name, $time, a.asrt, a.src[0], a.src[1], a.val[0], a.val[1], a.rel,
                  e.asrt, e.src[0], e.src[1], e.val[0], e.val[1], e.rel);
      end
   endtask

   task automatic check_zero(input string name);
      n_tests++;
      if (ifa.bus_asserted !== 1'b0 || ifa.station_release !== 4'b0000 ||
          ifa.bus_source[0] !== 2'd0 || ifa.bus_value[0] !== 32'h0 ||
          ifb.bus_asserted !== 2'b00 || ifb.station_release !== 3'b000 ||
          ifb.bus_source[0] !== 2'd0 || ifb.bus_source[1] !== 2'd0 ||
          ifb.bus_value[0] !== 32'h0 || ifb.bus_value[1] !== 32'h0) begin
         n_fail++;
         $display("FAIL %s @%0t: got A asrt=%b rel=%b src=%0d val=%h, B asrt=%b rel=%b, want all zero",
                  name, $time, ifa.bus_asserted, ifa.station_release, ifa.bus_source[0],
                  ifa.bus_value[0], ifb.bus_asserted, ifb.station_release);
      end
   endtask

   // Monitor: after every active edge, pop the expected lane state and
   // compare against what each instance presents.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (q_a.size() > 0) compare("lane_a", q_a.pop_front(), sample(0));
            if (q_b.size() > 0) compare("lane_b", q_b.pop_front(), sample(1));
         end
      end
   end

   // Stimulus: reset with everything ready, random traffic, one async
   // reset while a broadcast is on the bus, then drain and summarise.
   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) res[d][i] = $urandom;
         rdy[d]  = (d == 0) ? 4'b1111 : 4'b0111;
         drop[d] = 4'b0000;
         mrel[d] = 4'b0000;
         mptr[d] = 0;
      end
      rst_n = 1'b0;
      drive();
      repeat (3) @(negedge clk);
      check_zero("reset_hold");
      rst_n = 1'b1;
      model_step(0);
      model_step(1);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (!rst_done && c >= 1500 && ifa.bus_asserted[0] === 1'b1) begin
            rst_n = 1'b0;
            #1;
            check_zero("async_reset");
            for (int d = 0; d < 2; d++) begin
               mrel[d] = 4'b0000;
               mptr[d] = 0;
               drop[d] = 4'b0000;
            end
            q_a.delete();
            q_b.delete();
            @(negedge clk);
            check_zero("reset_held");
            rst_n    = 1'b1;
            rst_done = 1'b1;
         end
         dispatch(0);
         dispatch(1);
         drive();
         model_step(0);
         model_step(1);
      end

      @(posedge clk);
      #2;
      n_tests++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", q_a.size(), q_b.size());
      end
      n_tests++;
      if (!rst_done) begin
         n_fail++;
         $display("FAIL async_reset_window: got no broadcast on lane A after cycle 1500, want one");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
